// File: rtl/inst_encoder.sv
// inst_encoder: packs an ID/EX micro-op back into an RV32I word and emits it with a sequential PC.
// Optional ENCODER_NOP_ON_ILLEGAL_EN: emit NOP for illegal micro-ops instead of dropping them.
package inst_encoder_pkg;
    localparam logic [3:0] ALU_OP_ADD  = 4'h0;
    localparam logic [3:0] ALU_OP_SLL  = 4'h1;
    localparam logic [3:0] ALU_OP_SLT  = 4'h2;
    localparam logic [3:0] ALU_OP_SLTU = 4'h3;
    localparam logic [3:0] ALU_OP_XOR  = 4'h4;
    localparam logic [3:0] ALU_OP_SRL  = 4'h5;
    localparam logic [3:0] ALU_OP_OR   = 4'h6;
    localparam logic [3:0] ALU_OP_AND  = 4'h7;
    localparam logic [3:0] ALU_OP_SUB  = 4'h8;
    localparam logic [3:0] ALU_OP_SRA  = 4'hD;

    localparam logic [1:0] OPSEL_RS1 = 2'd0;
    localparam logic [1:0] OPSEL_PC  = 2'd1;
    localparam logic [1:0] OPSEL_RS2 = 2'd0;
    localparam logic [1:0] OPSEL_IMM = 2'd1;
    localparam logic [1:0] WB_ALU    = 2'd0;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
endpackage

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          ADDR_LEN = 32,
    parameter logic [31:0] PC_BASE  = 32'h0,
    parameter int          COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          alu_func,
    input  logic [1:0]          opsel1,
    input  logic [1:0]          opsel2,
    input  logic [1:0]          wbsel,
    input  logic                is_lui,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    input  logic [4:0]          rd_addr,
    input  logic                rf_w_en,
    input  logic                mem_w_en,
    input  logic [WIDTH-1:0]    imm,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    inst,
    output logic [ADDR_LEN-1:0] pc,
    output logic                illegal,
    output logic [COUNT_W-1:0]  inst_count,
    input  logic                clr_err
);

    logic                rdy_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    inst_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [ADDR_LEN-1:0] pc_next_q;
    logic                illegal_q;
    logic [COUNT_W-1:0]  cnt_q;

    logic [2:0]  f3;
    logic        f3_ok;
    logic        alt;
    logic        is_shift;
    logic        is_arith;
    logic        is_logic;
    logic        imm_s12;
    logic        imm_hi0;
    logic        shamt_ok;
    logic [31:0] enc_word;
    logic        bad;
    logic        accept;
    logic        emit;
    logic [31:0] emit_word;
    logic        out_hs;

    assign f3       = alu_func[2:0];
    assign f3_ok    = !alu_func[3] || alu_func == ALU_OP_SUB || alu_func == ALU_OP_SRA;
    assign alt      = alu_func == ALU_OP_SUB || alu_func == ALU_OP_SRA;
    assign is_shift = f3 == 3'd1 || f3 == 3'd5;
    assign is_arith = f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd3;
    assign is_logic = f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7;
    // Immediate fits a sign-extended 12-bit field
    assign imm_s12  = (&imm[31:11]) || !(|imm[31:11]);
    assign imm_hi0  = !(|imm[31:12]);
    assign shamt_ok = !(|imm[31:5]);

    always_comb begin
        enc_word = 32'h0;
        bad      = 1'b0;
        if (is_lui) begin
            enc_word = {imm[31:12], rd_addr, OP_LUI};
            bad      = |imm[11:0];
        end else if (opsel1 == OPSEL_PC) begin
            enc_word = {imm[31:12], rd_addr, OP_AUIPC};
            bad      = |imm[11:0];
        end else if (opsel1 == OPSEL_RS1 && opsel2 == OPSEL_RS2) begin
            enc_word = {1'b0, alt, 5'b0, rs2_addr, rs1_addr, f3, rd_addr, OP_RTYPE};
            bad      = !f3_ok;
        end else if (opsel1 == OPSEL_RS1 && opsel2 == OPSEL_IMM) begin
            if (is_shift) begin
                enc_word = {1'b0, alu_func == ALU_OP_SRA, 5'b0, imm[4:0],
                            rs1_addr, f3, rd_addr, OP_ITYPE};
            end else begin
                enc_word = {imm[11:0], rs1_addr, f3, rd_addr, OP_ITYPE};
            end
            bad = !f3_ok || alu_func == ALU_OP_SUB
                || (is_shift && !shamt_ok)
                || (is_arith && !imm_s12)
                || (is_logic && !imm_s12 && !imm_hi0);
        end else begin
            bad = 1'b1;
        end
        if (mem_w_en || !rf_w_en || wbsel != WB_ALU) begin
            bad = 1'b1;
        end
    end

    assign in_ready = rdy_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

`ifdef ENCODER_NOP_ON_ILLEGAL_EN
    assign emit      = accept;
    assign emit_word = bad ? 32'h0000_0013 : enc_word;
`else
    assign emit      = accept && !bad;
    assign emit_word = enc_word;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            pc_q        <= ADDR_LEN'(PC_BASE);
            pc_next_q   <= ADDR_LEN'(PC_BASE);
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (emit) begin
                out_valid_q <= 1'b1;
                inst_q      <= WIDTH'(emit_word);
                pc_q        <= pc_next_q;
                pc_next_q   <= pc_next_q + ADDR_LEN'(4);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A new illegal op wins over a same-cycle clear
            if (accept && bad) begin
                illegal_q <= 1'b1;
            end else if (clr_err) begin
                illegal_q <= 1'b0;
            end
            if (out_hs && !(&cnt_q)) begin
                cnt_q <= cnt_q + COUNT_W'(1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign illegal    = illegal_q;
    assign inst_count = cnt_q;

endmodule
